// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg
// Shared types and constants for the round-robin mux scheduler.
//   state_e    : scheduler state (IDLE between grants, GRANT while a requester
//                owns the shared channel)
//   N_REQ_DEF  : default requester count
//   DATA_W_DEF : default per-requester data width
//   clog2()    : ceiling log2, used to size and sanity-check select/counter widths
package mux_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int N_REQ_DEF  = 8;
    localparam int DATA_W_DEF = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// mux_rr_pick
// Combinational rotating-priority encoder: finds the first asserted request at
// or above ptr, wrapping modulo N_REQ.
//   req_valid [N_REQ] : candidate requests
//   ptr       [SEL_W] : index with highest priority this round
//   found     [1]     : at least one request is asserted
//   idx       [SEL_W] : winning index (0 when found is low)
module mux_rr_pick
    import mux_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int SEL_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] mask;
    logic [2*N_REQ-1:0] masked;

    // Two copies of the request vector side by side turn the wrap-around search
    // into a plain lowest-set-bit search: bits below ptr in the lower copy are
    // masked off, and the upper copy supplies the wrapped candidates.
    always_comb begin
        // NOTE: every signal driven here gets a value before any conditional
        // logic, so no path can hold an old value and infer a latch.
        dbl    = {req_valid, req_valid};
        mask   = {(2*N_REQ){1'b1}} << ptr;
        masked = dbl & mask;
        found  = |req_valid;
        idx    = '0;
        // Scan downward so the lowest set bit is the last one written.
        // N_REQ is a power of two, so truncating the bit position to SEL_W
        // bits folds the upper copy back onto requester indices.
        for (int i = 2*N_REQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler
// Round-robin scheduler sharing one valid/ready output channel among N_REQ
// requesters. A grant is held for a whole packet, cut after MAX_BURST beats,
// with one IDLE bubble cycle between grants. sel drives the select lines of
// the downstream 8:1 selection datapath.
//   clk, rst     : clock and synchronous active-high reset
//   req_valid    : per-requester valid         req_last : per-requester end of packet
//   req_data     : packed data, requester i at [i*DATA_W +: DATA_W]
//   req_ready    : per-requester accept, one-hot or zero
//   out_valid/out_data/out_last/out_ready : shared output channel
//   sel          : registered select code of the current grant
//   grant_active : high while a requester owns the channel
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SEL_W     = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        sel,
    output logic                    grant_active
);

    localparam int              CNT_W     = (MAX_BURST > 1) ? clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    if (SEL_W != clog2(N_REQ) || MAX_BURST < 1) begin : g_param_check
        $error("mux_rr_scheduler: SEL_W must equal clog2(N_REQ) and MAX_BURST must be >= 1");
    end

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    mux_rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        beat_cnt_d   = beat_cnt_q;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        req_ready    = '0;
        grant_active = 1'b0;

        // Outputs are forced idle while rst is high so a beat in flight on the
        // reset edge is never handed back to its requester as accepted.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        sel_d      = pick_idx;
                        beat_cnt_d = '0;
                        state_d    = GRANT;
                    end
                end
                GRANT: begin
                    grant_active     = 1'b1;
                    out_valid        = req_valid[sel_q];
                    out_data         = req_data[int'(sel_q) * DATA_W +: DATA_W];
                    out_last         = req_last[sel_q];
                    req_ready[sel_q] = out_ready;
                    if (out_valid && out_ready) begin
                        // End of packet or burst cap: move priority past the
                        // current owner so a cut packet queues behind the rest.
                        if (out_last || beat_cnt_q == LAST_BEAT) begin
                            ptr_d   = sel_q + SEL_W'(1);
                            state_d = IDLE;
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every register sample the values
        // from before the edge, independent of statement order.
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign sel = sel_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb_mux_rr_scheduler
// Directed scenarios plus randomized traffic against a transaction-level
// model of the round-robin rules (owner, priority pointer, beats sent).
module tb_mux_rr_scheduler;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int SW = 3;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;
    logic [SW-1:0]   sel;
    logic            grant_active;

    int n_checks = 0;
    int n_pass   = 0;

    // Observation vector: {grant_active, sel, out_valid, out_data, out_last, req_ready}
    logic [21:0] got;
    assign got = {grant_active, sel, out_valid, out_data, out_last, req_ready};

    always #5 clk = ~clk;

    mux_rr_scheduler #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .SEL_W     (SW),
        .MAX_BURST (MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .sel          (sel),
        .grant_active (grant_active)
    );

    // Transaction-level reference: who owns the channel, where the search
    // starts next, and how many beats the owner has sent in this grant.
    bit m_grant;
    int m_sel;
    int m_ptr;
    int m_beats;

    task automatic model_step();
        bit hit;
        if (rst) begin
            m_grant = 0; m_sel = 0; m_ptr = 0; m_beats = 0;
        end else if (!m_grant) begin
            hit = 0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!hit && req_valid[c]) begin
                    hit = 1; m_grant = 1; m_sel = c; m_beats = 0;
                end
            end
        end else if (req_valid[m_sel] && out_ready) begin
            m_beats++;
            if (req_last[m_sel] || m_beats == MB) begin
                m_grant = 0;
                m_ptr   = (m_sel + 1) % N;
            end
        end
    endtask

    function automatic logic [21:0] model_expect();
        logic [21:0] e;
        e = '0;
        e[20:18] = SW'(m_sel);
        if (m_grant && !rst) begin
            e[21]   = 1'b1;
            e[17]   = req_valid[m_sel];
            e[16:9] = req_data[m_sel*DW +: DW];
            e[8]    = req_last[m_sel];
            if (out_ready) e[m_sel] = 1'b1;
        end
        return e;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (got !== 22'h0) $display("FAIL reset_idle cycle %0d: got %h want %h", c, got, 22'h0);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_single();
        logic [21:0] want;
        do_reset();
        req_data[2*DW +: DW] = 8'hA5;
        req_last  = '1;
        out_ready = 1'b1;
        req_valid = 8'b0000_0100;
        @(negedge clk);
        want = 22'h0;
        n_checks++;
        if (got !== want) $display("FAIL single_idle: got %h want %h", got, want); else n_pass++;
        tick();
        @(negedge clk);
        want = {1'b1, 3'd2, 1'b1, 8'hA5, 1'b1, 8'h04};
        n_checks++;
        if (got !== want) $display("FAIL single_grant: got %h want %h", got, want); else n_pass++;
        tick();
        // Requesters 1 and 3 now compete; ptr=3 must favour 3.
        req_valid = 8'b0000_1010;
        req_data[1*DW +: DW] = 8'h11;
        req_data[3*DW +: DW] = 8'h33;
        @(negedge clk);
        want = {1'b0, 3'd2, 18'h0};
        n_checks++;
        if (got !== want) $display("FAIL single_bubble: got %h want %h", got, want); else n_pass++;
        tick();
        @(negedge clk);
        want = {1'b1, 3'd3, 1'b1, 8'h33, 1'b1, 8'h08};
        n_checks++;
        if (got !== want) $display("FAIL single_ptr_next: got %h want %h", got, want); else n_pass++;
        tick();
        req_valid = '0;
    endtask

    task automatic test_fairness();
        logic [21:0] want;
        int          held;
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'($urandom);
        req_valid = '1; req_last = '1; out_ready = 1'b1;
        held = 0;
        for (int k = 0; k < 9; k++) begin
            int r;
            r = k % N;
            @(negedge clk);
            want = {1'b0, SW'(held), 18'h0};
            n_checks++;
            if (got !== want) $display("FAIL rr_bubble %0d: got %h want %h", k, got, want); else n_pass++;
            tick();
            @(negedge clk);
            want = {1'b1, SW'(r), 1'b1, req_data[r*DW +: DW], 1'b1, 8'(1 << r)};
            n_checks++;
            if (got !== want) $display("FAIL rr_grant %0d: got %h want %h", k, got, want); else n_pass++;
            tick();
            held = r;
        end
        req_valid = '0;
    endtask

    task automatic test_burst_cap();
        int          own_t [11] = '{-1, 5, 5, 5, 5, -1, 6, -1, 5, 5, -1};
        logic [7:0]  dat_t [11] = '{8'h00, 8'h50, 8'h51, 8'h52, 8'h53, 8'h00, 8'h66, 8'h00, 8'h54, 8'h55, 8'h00};
        bit          lst_t [11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        logic [21:0] want;
        logic [N-1:0] rr;
        int          b5, held;
        bit          sent6;
        do_reset();
        b5 = 0; sent6 = 0; held = 0; out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            req_valid = '0; req_last = '0;
            req_valid[5] = (b5 < 6);
            req_data[5*DW +: DW] = 8'h50 + 8'(b5);
            req_last[5] = (b5 == 5);
            req_valid[6] = !sent6;
            req_data[6*DW +: DW] = 8'h66;
            req_last[6] = 1'b1;
            @(negedge clk);
            if (own_t[c] < 0) begin
                want = {1'b0, SW'(held), 18'h0};
            end else begin
                want = {1'b1, SW'(own_t[c]), 1'b1, dat_t[c], lst_t[c], 8'(1 << own_t[c])};
                held = own_t[c];
            end
            n_checks++;
            if (got !== want) $display("FAIL burst_cap cycle %0d: got %h want %h", c, got, want); else n_pass++;
            rr = req_ready;
            tick();
            if (rr[5]) b5++;
            if (rr[6]) sent6 = 1;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        bit          rp [8] = '{0, 0, 0, 1, 1, 0, 1, 1};
        logic [21:0] want;
        logic [N-1:0] rr;
        int          s, acc;
        do_reset();
        s = 0; acc = 0;
        req_valid[3] = 1'b1;
        req_data[3*DW +: DW] = 8'h30;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (got !== 22'h0) $display("FAIL bp_bubble: got %h want %h", got, 22'h0); else n_pass++;
        tick();
        for (int j = 0; j < 8; j++) begin
            out_ready = rp[j];
            req_data[3*DW +: DW] = 8'h30 + 8'(s);
            @(negedge clk);
            want = {1'b1, 3'd3, 1'b1, 8'h30 + 8'(acc), 1'b0, rp[j] ? 8'h08 : 8'h00};
            n_checks++;
            if (got !== want) $display("FAIL bp_cycle %0d: got %h want %h", j, got, want); else n_pass++;
            rr = req_ready;
            tick();
            if (rr[3]) s++;
            if (rp[j]) acc++;
        end
        @(negedge clk);
        want = {1'b0, 3'd3, 18'h0};
        n_checks++;
        if (got !== want) $display("FAIL bp_cap_release: got %h want %h", got, want); else n_pass++;
        n_checks++;
        if (s !== 4) $display("FAIL bp_beats_taken: got %0d want %0d", s, 4); else n_pass++;
        tick();
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [21:0] want;
        logic [N-1:0] rr;
        int          s;
        do_reset();
        s = 0;
        out_ready = 1'b1;
        req_valid[7] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            req_data[7*DW +: DW] = 8'h70 + 8'(s);
            req_last[7] = (s == 3);
            rst = (c == 3);
            @(negedge clk);
            case (c)
                0:       want = 22'h0;
                1, 2:    want = {1'b1, 3'd7, 1'b1, 8'h70 + 8'(c - 1), 1'b0, 8'h80};
                3:       want = {1'b0, 3'd7, 18'h0};
                4:       want = 22'h0;
                default: want = {1'b1, 3'd7, 1'b1, 8'h72, 1'b0, 8'h80};
            endcase
            n_checks++;
            if (got !== want) $display("FAIL reset_mid cycle %0d: got %h want %h", c, got, want); else n_pass++;
            if (c == 4) begin
                n_checks++;
                if (s !== 2) $display("FAIL reset_mid_beats: got %0d want %0d", s, 2); else n_pass++;
            end
            rr = req_ready;
            tick();
            if (rr[7]) s++;
        end
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_random();
        logic [21:0] want;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            if (c % 50 < 10) req_valid = req_valid & N'($urandom);
            req_last  = N'($urandom & $urandom);
            req_data  = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            want = model_expect();
            n_checks++;
            if (got !== want) $display("FAIL random cycle %0d: got %h want %h", c, got, want); else n_pass++;
            n_checks++;
            if (!$onehot0(req_ready)) $display("FAIL random_onehot cycle %0d: got %b want one-hot or zero", c, req_ready);
            else n_pass++;
            tick();
        end
        rst = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        m_grant = 0; m_sel = 0; m_ptr = 0; m_beats = 0;
        test_reset();
        test_single();
        test_fairness();
        test_burst_cap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
